// File: rtl/fib_capture_pkg.sv
// Shared register map, bit positions and CTRL layout for fib_capture.
package fib_capture_pkg;

  // Word offsets within the 16-byte window (byte address bits [3:2])
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_DROPS  = 2'd3;

  // CTRL bit positions
  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;
  localparam int unsigned CTRL_THR_LSB    = 8;
  localparam int unsigned CTRL_THR_W      = 8;

  // STATUS bit positions
  localparam int unsigned STATUS_COUNT_LSB = 0;
  localparam int unsigned STATUS_COUNT_W   = 16;
  localparam int unsigned STATUS_EMPTY_BIT = 16;
  localparam int unsigned STATUS_FULL_BIT  = 17;
  localparam int unsigned STATUS_DROPS_BIT = 18;

  localparam int unsigned DROPS_W = 16;

  // Architectural CTRL state (reserved bits are not stored)
  typedef struct packed {
    logic [CTRL_THR_W-1:0] thr;
    logic                  irq_en;
    logic                  en;
  } ctrl_t;

  // A threshold of zero behaves as one, so an empty FIFO never interrupts
  function automatic logic [CTRL_THR_W-1:0] eff_threshold(input logic [CTRL_THR_W-1:0] thr);
    return (thr == CTRL_THR_W'(0)) ? CTRL_THR_W'(1) : thr;
  endfunction

endpackage

// File: rtl/fib_fifo.sv
// Synchronous FIFO with occupancy count; simultaneous push/pop allowed when full.
module fib_fifo #(
  parameter int unsigned WIDTH = 30,
  parameter int unsigned DEPTH = 16
) (
  input  logic                         wb_clk_i,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == CNT_W'(0));
  assign count     = r_count;
  assign rdata     = r_mem[r_rd_ptr];
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  // Storage array, written at the tail
  always_ff @(posedge wb_clk_i) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/fib_capture.sv
// Captures each new stable value of the fibonacci bus into a FIFO readable over Wishbone.
module fib_capture
  import fib_capture_pkg::*;
#(
  parameter int unsigned WIDTH     = 30,
  parameter int unsigned DEPTH     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0100
) (
  input  logic             wb_clk_i,
  input  logic             reset_n,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_dat_i,
  input  logic [31:0]      wbs_adr_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  input  logic [WIDTH-1:0] value_in,
  output logic             irq
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  // Sampler
  logic [WIDTH-1:0]   r_s1;
  logic [WIDTH-1:0]   r_s2;
  logic [WIDTH-1:0]   r_last;
  logic               r_last_valid;
  logic               w_stable;
  logic               w_capture;

  // Bus and registers
  logic               r_ack;
  logic [31:0]        r_dat;
  logic               r_irq;
  ctrl_t              r_ctrl;
  logic [DROPS_W-1:0] r_drops;
  logic               w_in_window;
  logic               w_hit;
  logic               w_rd;
  logic               w_wr;
  logic [1:0]         w_off;
  logic               w_ctrl_wr;
  logic               w_drops_clr;
  logic [31:0]        w_rdata;

  // FIFO interface
  logic               w_push;
  logic               w_pop;
  logic               w_drop;
  logic [WIDTH-1:0]   w_fifo_rdata;
  logic [CNT_W-1:0]   w_count;
  logic               w_full;
  logic               w_empty;

  // Reserved write bits and sub-word address bits carry no meaning
  logic w_unused;
  assign w_unused = &{1'b0, wbs_sel_i[3:2], wbs_dat_i[31:16], wbs_dat_i[7:2], wbs_adr_i[1:0]};

  assign w_stable    = (r_s1 == r_s2);
  assign w_capture   = r_ctrl.en & w_stable & (~r_last_valid | (r_s2 != r_last));

  assign w_in_window = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign w_hit       = wbs_stb_i & wbs_cyc_i & w_in_window & ~r_ack;
  assign w_off       = wbs_adr_i[3:2];
  assign w_rd        = w_hit & ~wbs_we_i;
  assign w_wr        = w_hit & wbs_we_i;
  assign w_ctrl_wr   = w_wr & (w_off == REG_CTRL);
  assign w_drops_clr = w_wr & (w_off == REG_DROPS);

  assign w_pop       = w_rd & (w_off == REG_DATA) & ~w_empty;
  assign w_push      = w_capture & (~w_full | w_pop);
  assign w_drop      = w_capture & w_full & ~w_pop;

  fib_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .wb_clk_i (wb_clk_i),
    .reset_n  (reset_n),
    .push     (w_push),
    .pop      (w_pop),
    .wdata    (r_s2),
    .rdata    (w_fifo_rdata),
    .count    (w_count),
    .full     (w_full),
    .empty    (w_empty)
  );

  // Two-stage sampler plus last-captured tracking; enabling restarts capture
  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_s1         <= '0;
      r_s2         <= '0;
      r_last       <= '0;
      r_last_valid <= 1'b0;
    end else begin
      r_s1 <= value_in;
      r_s2 <= r_s1;
      if (w_capture) r_last <= r_s2;
      if (w_ctrl_wr && wbs_sel_i[0] && wbs_dat_i[CTRL_EN_BIT] && !r_ctrl.en) begin
        r_last_valid <= 1'b0;
      end else if (w_capture) begin
        r_last_valid <= 1'b1;
      end
    end
  end

  // Read data mux for the addressed register
  always_comb begin
    w_rdata = '0;
    unique case (w_off)
      REG_DATA: begin
        if (!w_empty) w_rdata = 32'(w_fifo_rdata);
      end
      REG_STATUS: begin
        w_rdata[STATUS_COUNT_LSB +: STATUS_COUNT_W] = STATUS_COUNT_W'(w_count);
        w_rdata[STATUS_EMPTY_BIT]                    = w_empty;
        w_rdata[STATUS_FULL_BIT]                     = w_full;
        w_rdata[STATUS_DROPS_BIT]                    = (r_drops != '0);
      end
      REG_CTRL: begin
        w_rdata[CTRL_EN_BIT]                     = r_ctrl.en;
        w_rdata[CTRL_IRQ_EN_BIT]                 = r_ctrl.irq_en;
        w_rdata[CTRL_THR_LSB +: CTRL_THR_W]      = r_ctrl.thr;
      end
      REG_DROPS: begin
        w_rdata[DROPS_W-1:0] = r_drops;
      end
      default: w_rdata = '0;
    endcase
  end

  // Single-cycle registered acknowledge; data is driven only alongside a read ack
  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_hit;
      r_dat <= w_rd ? w_rdata : 32'h0;
    end
  end

  // CTRL register with per-byte write enables
  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_ctrl <= '0;
    end else if (w_ctrl_wr) begin
      if (wbs_sel_i[0]) begin
        r_ctrl.en     <= wbs_dat_i[CTRL_EN_BIT];
        r_ctrl.irq_en <= wbs_dat_i[CTRL_IRQ_EN_BIT];
      end
      if (wbs_sel_i[1]) begin
        r_ctrl.thr <= wbs_dat_i[CTRL_THR_LSB +: CTRL_THR_W];
      end
    end
  end

  // Saturating drop counter; a software clear beats a coincident drop
  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_drops <= '0;
    end else if (w_drops_clr) begin
      r_drops <= '0;
    end else if (w_drop && (r_drops != {DROPS_W{1'b1}})) begin
      r_drops <= r_drops + DROPS_W'(1);
    end
  end

  // Level interrupt on fill threshold, one cycle behind the count
  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_ctrl.irq_en &
               (STATUS_COUNT_W'(w_count) >= STATUS_COUNT_W'(eff_threshold(r_ctrl.thr)));
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign irq       = r_irq;

endmodule

// File: tb/tb_fib_capture.sv
// Randomized and directed bench for fib_capture against a queue-based behavioural model.
module tb_fib_capture;

  localparam int          WIDTH = 30;
  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h3000_0100;

  logic             wb_clk_i;
  logic             reset_n;
  logic             wbs_stb_i;
  logic             wbs_cyc_i;
  logic             wbs_we_i;
  logic [3:0]       wbs_sel_i;
  logic [31:0]      wbs_dat_i;
  logic [31:0]      wbs_adr_i;
  logic             wbs_ack_o;
  logic [31:0]      wbs_dat_o;
  logic [WIDTH-1:0] value_in;
  logic             irq;

  fib_capture #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .reset_n   (reset_n),
    .wbs_stb_i (wbs_stb_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .value_in  (value_in),
    .irq       (irq)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // h1/h2 are the last two bus samples; a value is taken once it has been
  // seen twice in a row and differs from the last value taken.
  logic [WIDTH-1:0] h1 = '0, h2 = '0, m_last = '0;
  bit               m_lv = 0;
  logic [WIDTH-1:0] mq[$];
  int               m_drops = 0;
  bit               m_en = 0, m_irq_en = 0;
  logic [7:0]       m_thr = '0;
  logic             m_ack = 1'b0;
  logic [31:0]      m_dat = '0;
  logic             m_irq = 1'b0;
  // scratch for the model process only
  bit               t_cap, t_hit, t_pop, t_old_en, t_irq;
  int               t_sz, t_thr;
  logic [1:0]       t_off;
  logic [31:0]      t_rd;

  always @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      h1 = '0; h2 = '0; m_last = '0; m_lv = 0;
      mq.delete();
      m_drops = 0; m_en = 0; m_irq_en = 0; m_thr = '0;
      m_ack = 1'b0; m_dat = '0; m_irq = 1'b0;
    end else begin
      t_sz  = mq.size();
      t_cap = m_en && (h1 == h2) && (!m_lv || (h2 != m_last));
      t_hit = wbs_stb_i && wbs_cyc_i && ((wbs_adr_i & 32'hFFFF_FFF0) == BASE) && !m_ack;
      t_off = wbs_adr_i[3:2];
      t_thr = (m_thr == 8'd0) ? 1 : int'(m_thr);
      t_irq = m_irq_en && (t_sz >= t_thr);
      t_rd  = '0;
      if (t_hit && !wbs_we_i) begin
        case (t_off)
          2'd0: if (t_sz > 0) t_rd = 32'(mq[0]);
          2'd1: t_rd = {13'b0, m_drops != 0, t_sz == DEPTH, t_sz == 0, 16'(t_sz)};
          2'd2: t_rd = {16'b0, m_thr, 6'b0, m_irq_en, m_en};
          default: t_rd = 32'(m_drops);
        endcase
      end
      t_pop = t_hit && !wbs_we_i && (t_off == 2'd0) && (t_sz > 0);
      if (t_pop) void'(mq.pop_front());
      if (t_cap) begin
        if (t_sz < DEPTH || t_pop) mq.push_back(h2);
        else if (m_drops < 16'hFFFF) m_drops++;
        m_last = h2;
        m_lv   = 1;
      end
      if (t_hit && wbs_we_i && t_off == 2'd3) m_drops = 0;
      t_old_en = m_en;
      if (t_hit && wbs_we_i && t_off == 2'd2) begin
        if (wbs_sel_i[0]) begin
          m_en     = wbs_dat_i[0];
          m_irq_en = wbs_dat_i[1];
        end
        if (wbs_sel_i[1]) m_thr = wbs_dat_i[15:8];
        if (!t_old_en && m_en) m_lv = 0;
      end
      m_ack = t_hit;
      m_dat = t_rd;
      m_irq = t_irq;
      h2 = h1;
      h1 = value_in;
    end
  end

  // Cycle-by-cycle comparison of all outputs, away from the active edge
  always @(negedge wb_clk_i) begin
    chk("ack", 32'(wbs_ack_o), 32'(m_ack));
    chk("dat_o", wbs_dat_o, m_dat);
    chk("irq", 32'(irq), 32'(m_irq));
  end

  // ---------------- stimulus helpers (all start at a falling edge) ----------------
  task automatic bus(input bit we, input logic [31:0] adr, input logic [31:0] wd,
                     input logic [3:0] sel, input bit expect_ack, output logic [31:0] rd);
    bit got;
    got = 0;
    rd  = '0;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = wd;   wbs_sel_i = sel;
    for (int i = 0; i < 6; i++) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o) begin
        got = 1;
        rd  = wbs_dat_o;
        break;
      end
    end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    chk(expect_ack ? "bus_ack" : "no_ack_outside", 32'(got), 32'(expect_ack));
  endtask

  task automatic rd_reg(input logic [3:0] off, output logic [31:0] rd);
    bus(1'b0, BASE + 32'(off), 32'h0, 4'hF, 1'b1, rd);
  endtask

  task automatic wr_reg(input logic [3:0] off, input logic [31:0] wd);
    logic [31:0] dummy;
    bus(1'b1, BASE + 32'(off), wd, 4'hF, 1'b1, dummy);
  endtask

  task automatic hold(input logic [WIDTH-1:0] v, input int n);
    value_in = v;
    repeat (n) @(negedge wb_clk_i);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  logic [31:0] r;
  logic [31:0] exp5 [5];

  initial begin
    wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0; wbs_sel_i = 0;
    wbs_dat_i = 0; wbs_adr_i = 0; value_in = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    reset_n = 1'b1;
    @(negedge wb_clk_i);

    rd_reg(4'h4, r); chk("reset_status", r, 32'h0001_0000);
    rd_reg(4'h8, r); chk("reset_ctrl", r, 32'h0);

    // Basic capture sequence: repeated 1 is stored once
    wr_reg(4'h8, 32'h1);
    hold(0, 8); hold(1, 8); hold(1, 8); hold(2, 8); hold(3, 8); hold(5, 8);
    exp5 = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd5};
    for (int i = 0; i < 5; i++) begin
      rd_reg(4'h0, r); chk("seq_data", r, exp5[i]);
    end
    rd_reg(4'h4, r); chk("seq_status_empty", r, 32'h0001_0000);
    rd_reg(4'h0, r); chk("empty_read", r, 32'h0);

    // One-cycle glitch never becomes stable
    hold(7, 1); hold(5, 8);
    rd_reg(4'h4, r); chk("glitch_status", r, 32'h0001_0000);

    // Overflow: 18 distinct values into 16 slots
    for (int i = 0; i < 18; i++) hold(WIDTH'(100 + i), 4);
    rd_reg(4'h4, r); chk("full_status", r, 32'h0006_0010);
    rd_reg(4'hC, r); chk("drops_two", r, 32'd2);
    wr_reg(4'hC, 32'h0);
    rd_reg(4'hC, r); chk("drops_cleared", r, 32'd0);
    rd_reg(4'h4, r); chk("status_after_clear", r, 32'h0002_0010);
    rd_reg(4'h0, r); chk("first_of_full", r, 32'd100);

    // Refill, then capture and pop on the same edge
    hold(118, 4);
    rd_reg(4'h4, r); chk("refull_status", r, 32'h0002_0010);
    value_in = WIDTH'(119);
    @(negedge wb_clk_i); @(negedge wb_clk_i);
    rd_reg(4'h0, r); chk("pop_push_data", r, 32'd101);
    rd_reg(4'h4, r); chk("pop_push_status", r, 32'h0002_0010);
    rd_reg(4'hC, r); chk("pop_push_drops", r, 32'd0);
    for (int i = 0; i < 16; i++) begin
      rd_reg(4'h0, r);
      if (i == 0)  chk("drain_first", r, 32'd102);
      if (i == 15) chk("drain_tail", r, 32'd119);
    end

    // Threshold interrupt
    wr_reg(4'h8, 32'h0000_0403);
    hold(200, 4); hold(201, 4); hold(202, 4);
    chk("irq_below", 32'(irq), 32'd0);
    hold(203, 4);
    chk("irq_at_thr", 32'(irq), 32'd1);
    rd_reg(4'h0, r); chk("irq_pop_data", r, 32'd200);
    chk("irq_lags_count", 32'(irq), 32'd1);
    @(negedge wb_clk_i);
    chk("irq_fell", 32'(irq), 32'd0);
    hold(204, 4); hold(205, 4);
    rd_reg(4'h4, r); chk("count_five", r, 32'h0000_0005);

    // Reset during an in-flight request
    wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = 0; wbs_adr_i = BASE + 32'h4; wbs_sel_i = 4'hF;
    #2 reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge wb_clk_i);
      chk("ack_lost_in_reset", 32'(wbs_ack_o), 32'd0);
    end
    wbs_stb_i = 0; wbs_cyc_i = 0;
    reset_n = 1'b1;
    @(negedge wb_clk_i);
    chk("irq_after_reset", 32'(irq), 32'd0);
    rd_reg(4'h4, r); chk("status_after_reset", r, 32'h0001_0000);
    rd_reg(4'h8, r); chk("ctrl_after_reset", r, 32'h0);
    bus(1'b0, BASE + 32'h10, 32'h0, 4'hF, 1'b0, r);
    bus(1'b0, 32'h3000_0000, 32'h0, 4'hF, 1'b0, r);
    bus(1'b1, BASE - 32'h4, 32'h1, 4'hF, 1'b0, r);
    rd_reg(4'h8, r); chk("ctrl_untouched_by_outside_write", r, 32'h0);

    // Randomized traffic, checked every cycle by the model
    wr_reg(4'h8, {16'h0, 8'($urandom_range(0, 20)), 6'h0, 1'($urandom_range(0, 1)), 1'b1});
    fork
      begin
        for (int n = 0; n < 700; n++) begin
          if ($urandom_range(0, 9) == 0) value_in = WIDTH'($urandom);
          else value_in = WIDTH'($urandom_range(0, 7));
          repeat ($urandom_range(1, 6)) @(negedge wb_clk_i);
        end
      end
      begin
        for (int n = 0; n < 350; n++) begin
          logic [31:0] rr;
          int k;
          repeat ($urandom_range(0, 3)) @(negedge wb_clk_i);
          k = $urandom_range(0, 11);
          case (k)
            0, 1, 2: rd_reg(4'h0, rr);
            3: rd_reg(4'h4, rr);
            4: rd_reg(4'h8, rr);
            5: rd_reg(4'hC, rr);
            6, 7: bus(1'b1, BASE + 32'h8,
                      {16'($urandom), 8'($urandom_range(0, 18)), 6'($urandom),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) != 0)},
                      4'($urandom), 1'b1, rr);
            8: bus(1'b1, BASE + 32'hC, $urandom, 4'($urandom), 1'b1, rr);
            9: bus(1'b1, BASE + 32'(4 * $urandom_range(0, 1)), $urandom, 4'hF, 1'b1, rr);
            10: bus(1'b0, BASE + 32'h20 + 32'(4 * $urandom_range(0, 3)), 32'h0, 4'hF, 1'b0, rr);
            default: rd_reg(4'h4, rr);
          endcase
        end
      end
    join

    repeat (4) @(negedge wb_clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
